// File: rtl/ddr_burst_arbiter.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif

// Per-channel round-robin owner FSM: one outstanding burst, IDLE -> ISSUE -> BUSY.
// Latency: request seen in IDLE -> grant plus single-cycle burst_req on the next cycle.
// Backpressure: requesters wait while the channel is owned; DDR finish releases it.
module ddr_burst_arb_chan #(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter int LW = 8
) (
    input  logic            user_clk,
    input  logic            user_rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    input  logic [N*LW-1:0] len,
    input  logic            burst_finish,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic [AW-1:0]   burst_addr,
    output logic [LW-1:0]   burst_len,
    output logic            burst_req
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, idx, sel_idx;
    logic [IW:0]   cand;
    logic          sel_vld, load, done;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        cand    = '0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!sel_vld && req[cand[IW-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        burst_req = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                burst_req = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (burst_finish) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            grant      <= '0;
            burst_addr <= '0;
            burst_len  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                idx        <= sel_idx;
                grant      <= (N)'(1) << sel_idx;
                burst_addr <= addr[sel_idx*AW +: AW];
                burst_len  <= len[sel_idx*LW +: LW];
            end
            if (done) begin
                grant <= '0;
                ptr   <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    assign busy = (state == BUSY);
endmodule

// Shares the DDR burst user interface between NUM_RD readers and NUM_WR writers, round-robin per channel.
// Latency: grant and burst_*_req one cycle after request; data/valid/finish routed combinationally.
// Backpressure: one burst in flight per channel; others hold req until granted.
module ddr_burst_arbiter #(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                             user_clk,
    input  logic                             user_rst,
    input  logic [NUM_RD-1:0]                rd_req,
    input  logic [NUM_RD*`ADDR_SIZE-1:0]     rd_addr,
    input  logic [NUM_RD*`LEN_WIDTH-1:0]     rd_len,
    output logic [NUM_RD-1:0]                rd_grant,
    output logic [`DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_RD-1:0]                rd_valid,
    output logic [NUM_RD-1:0]                rd_finish,
    input  logic [NUM_WR-1:0]                wr_req,
    input  logic [NUM_WR*`ADDR_SIZE-1:0]     wr_addr,
    input  logic [NUM_WR*`LEN_WIDTH-1:0]     wr_len,
    input  logic [NUM_WR*`DATA_WIDTH-1:0]    wr_data,
    output logic [NUM_WR-1:0]                wr_grant,
    output logic [NUM_WR-1:0]                wr_valid,
    output logic [NUM_WR-1:0]                wr_finish,
    output logic [`ADDR_SIZE-1:0]            burst_read_addr,
    output logic [`LEN_WIDTH-1:0]            burst_read_len,
    output logic                             burst_read_req,
    input  logic [`DATA_WIDTH-1:0]           burst_read_data,
    input  logic                             burst_read_valid,
    input  logic                             burst_read_finish,
    output logic [`ADDR_SIZE-1:0]            burst_write_addr,
    output logic [`LEN_WIDTH-1:0]            burst_write_len,
    output logic                             burst_write_req,
    output logic [`DATA_WIDTH-1:0]           burst_write_data,
    input  logic                             burst_write_valid,
    input  logic                             burst_write_finish
);
    localparam int DW = `DATA_WIDTH;

    logic rd_busy, wr_busy;

    ddr_burst_arb_chan #(.N(NUM_RD), .AW(`ADDR_SIZE), .LW(`LEN_WIDTH)) u_rd_chan (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .req          (rd_req),
        .addr         (rd_addr),
        .len          (rd_len),
        .burst_finish (burst_read_finish),
        .grant        (rd_grant),
        .busy         (rd_busy),
        .burst_addr   (burst_read_addr),
        .burst_len    (burst_read_len),
        .burst_req    (burst_read_req)
    );

    ddr_burst_arb_chan #(.N(NUM_WR), .AW(`ADDR_SIZE), .LW(`LEN_WIDTH)) u_wr_chan (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .req          (wr_req),
        .addr         (wr_addr),
        .len          (wr_len),
        .burst_finish (burst_write_finish),
        .grant        (wr_grant),
        .busy         (wr_busy),
        .burst_addr   (burst_write_addr),
        .burst_len    (burst_write_len),
        .burst_req    (burst_write_req)
    );

    // Strobes only reach the owner once its burst is in flight; stray DDR strobes in IDLE/ISSUE are dropped.
    always_comb begin
        rd_valid  = rd_busy ? ({NUM_RD{burst_read_valid}} & rd_grant) : '0;
        rd_finish = rd_busy ? ({NUM_RD{burst_read_finish}} & rd_grant) : '0;
        wr_valid  = wr_busy ? ({NUM_WR{burst_write_valid}} & wr_grant) : '0;
        wr_finish = wr_busy ? ({NUM_WR{burst_write_finish}} & wr_grant) : '0;
    end

    assign rd_data = burst_read_data;

    always_comb begin
        burst_write_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_grant[i]) burst_write_data = burst_write_data | wr_data[i*DW +: DW];
        end
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif

// Directed bench for ddr_burst_arbiter with a DDR memory model, auto-behaving masters,
// a per-cycle transaction-level owner model, and literal expectations per scenario.
module tb_ddr_burst_arbiter;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int DW = `DATA_WIDTH;
    localparam int AW = `ADDR_SIZE;
    localparam int LW = `LEN_WIDTH;

    logic                   user_clk = 1'b0;
    logic                   user_rst = 1'b1;
    logic [NUM_RD-1:0]      rd_req = '0;
    logic [NUM_RD*AW-1:0]   rd_addr = '0;
    logic [NUM_RD*LW-1:0]   rd_len = '0;
    logic [NUM_RD-1:0]      rd_grant, rd_valid, rd_finish;
    logic [DW-1:0]          rd_data;
    logic [NUM_WR-1:0]      wr_req = '0;
    logic [NUM_WR*AW-1:0]   wr_addr = '0;
    logic [NUM_WR*LW-1:0]   wr_len = '0;
    logic [NUM_WR*DW-1:0]   wr_data = '0;
    logic [NUM_WR-1:0]      wr_grant, wr_valid, wr_finish;
    logic [AW-1:0]          burst_read_addr, burst_write_addr;
    logic [LW-1:0]          burst_read_len, burst_write_len;
    logic                   burst_read_req, burst_write_req;
    logic [DW-1:0]          burst_read_data = '0;
    logic                   burst_read_valid = 1'b0, burst_read_finish = 1'b0;
    logic [DW-1:0]          burst_write_data;
    logic                   burst_write_valid = 1'b0, burst_write_finish = 1'b0;

    ddr_burst_arbiter #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .user_clk(user_clk), .user_rst(user_rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_grant(rd_grant), .rd_data(rd_data), .rd_valid(rd_valid), .rd_finish(rd_finish),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_valid(wr_valid), .wr_finish(wr_finish),
        .burst_read_addr(burst_read_addr), .burst_read_len(burst_read_len), .burst_read_req(burst_read_req),
        .burst_read_data(burst_read_data), .burst_read_valid(burst_read_valid), .burst_read_finish(burst_read_finish),
        .burst_write_addr(burst_write_addr), .burst_write_len(burst_write_len), .burst_write_req(burst_write_req),
        .burst_write_data(burst_write_data), .burst_write_valid(burst_write_valid), .burst_write_finish(burst_write_finish)
    );

    always #5 user_clk = ~user_clk;

    logic [DW-1:0] mem [0:255];

    // Master intent
    int            rd_want [NUM_RD];
    logic [AW-1:0] rd_a    [NUM_RD];
    logic [LW-1:0] rd_l    [NUM_RD];
    int            wr_want [NUM_WR];
    logic [AW-1:0] wr_a    [NUM_WR];
    logic [LW-1:0] wr_l    [NUM_WR];
    logic [DW-1:0] wr_base [NUM_WR];
    logic [7:0]    wr_k    [NUM_WR];
    logic          rst_want;

    // DDR model state
    bit         drd_busy, dwr_busy;
    int         drd_wait, dwr_wait;
    logic [7:0] drd_addr, drd_len, drd_beat;
    logic [7:0] dwr_addr, dwr_len, dwr_beat, dwr_cur;

    // Values seen at the last falling edge
    logic [NUM_RD-1:0] s_rd_fin;
    logic [NUM_WR-1:0] s_wr_vld, s_wr_fin;

    // Owner model: -1 = channel free; iss = the single request cycle
    int            mr_own, mr_ptr, mw_own, mw_ptr;
    bit            mr_iss, mw_iss;
    logic [AW-1:0] mr_addr, mw_addr;
    logic [LW-1:0] mr_len, mw_len;

    // Statistics for the literal expectations
    int            rd_beats [NUM_RD];
    int            rd_fin   [NUM_RD];
    logic [7:0]    rd_k     [NUM_RD];
    int            wr_beats [NUM_WR];
    int            wr_fin   [NUM_WR];
    int            rd_order [$];
    int            wr_order [$];
    logic [AW-1:0] last_ra, last_wa;
    logic [LW-1:0] last_rl, last_wl;
    logic [DW-1:0] first_rd_data, last_rd_data;
    bit            got_first, both_seen;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < NUM_RD; i++) begin rd_beats[i] = 0; rd_fin[i] = 0; end
        for (int i = 0; i < NUM_WR; i++) begin wr_beats[i] = 0; wr_fin[i] = 0; end
        rd_order.delete();
        wr_order.delete();
        got_first = 1'b0;
        both_seen = 1'b0;
    endtask

    // Just after the rising edge: DDR write capture, master reactions, DDR responses.
    task automatic drive();
        if (burst_write_valid) mem[dwr_cur] = burst_write_data;
        for (int i = 0; i < NUM_RD; i++)
            if (s_rd_fin[i] && rd_want[i] > 0) rd_want[i]--;
        for (int i = 0; i < NUM_WR; i++) begin
            if (s_wr_vld[i]) wr_k[i] = wr_k[i] + 8'd1;
            if (s_wr_fin[i]) begin
                wr_k[i] = 8'd0;
                if (wr_want[i] > 0) wr_want[i]--;
            end
        end
        user_rst = rst_want;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_req[i] = (rd_want[i] > 0);
            rd_addr[i*AW +: AW] = rd_a[i];
            rd_len[i*LW +: LW] = rd_l[i];
        end
        for (int i = 0; i < NUM_WR; i++) begin
            wr_req[i] = (wr_want[i] > 0);
            wr_addr[i*AW +: AW] = wr_a[i];
            wr_len[i*LW +: LW] = wr_l[i];
            wr_data[i*DW +: DW] = wr_base[i] + {56'd0, wr_k[i]};
        end
        burst_read_valid = 1'b0;
        burst_read_finish = 1'b0;
        if (rst_want) drd_busy = 1'b0;
        else if (drd_busy) begin
            if (drd_wait > 0) drd_wait--;
            else if (drd_beat < drd_len) begin
                burst_read_valid = 1'b1;
                burst_read_data = mem[drd_addr + drd_beat];
                drd_beat = drd_beat + 8'd1;
            end else begin
                burst_read_finish = 1'b1;
                drd_busy = 1'b0;
            end
        end else if (burst_read_req) begin
            drd_busy = 1'b1; drd_wait = 1; drd_beat = 8'd0;
            drd_addr = burst_read_addr[10:3];
            drd_len = burst_read_len;
        end
        burst_write_valid = 1'b0;
        burst_write_finish = 1'b0;
        if (rst_want) dwr_busy = 1'b0;
        else if (dwr_busy) begin
            if (dwr_wait > 0) dwr_wait--;
            else if (dwr_beat < dwr_len) begin
                burst_write_valid = 1'b1;
                dwr_cur = dwr_addr + dwr_beat;
                dwr_beat = dwr_beat + 8'd1;
            end else begin
                burst_write_finish = 1'b1;
                dwr_busy = 1'b0;
            end
        end else if (burst_write_req) begin
            dwr_busy = 1'b1; dwr_wait = 1; dwr_beat = 8'd0;
            dwr_addr = burst_write_addr[10:3];
            dwr_len = burst_write_len;
        end
    endtask

    // At the falling edge: compare against the owner model, gather stats, advance the model.
    task automatic sample();
        logic [NUM_RD-1:0] erg, erv, erf;
        logic [NUM_WR-1:0] ewg, ewv, ewf;
        logic [DW-1:0]     ewd;
        s_rd_fin = rd_finish;
        s_wr_vld = wr_valid;
        s_wr_fin = wr_finish;
        if (!chk_on) return;
        erg = (mr_own >= 0) ? (NUM_RD'(1) << mr_own) : '0;
        erv = (mr_own >= 0 && !mr_iss && burst_read_valid) ? erg : '0;
        erf = (mr_own >= 0 && !mr_iss && burst_read_finish) ? erg : '0;
        chk("rd_grant", rd_grant, erg);
        chk("burst_read_req", burst_read_req, (mr_own >= 0 && mr_iss));
        if (mr_own >= 0 && mr_iss) begin
            chk("burst_read_addr", burst_read_addr, mr_addr);
            chk("burst_read_len", burst_read_len, mr_len);
        end
        chk("rd_valid", rd_valid, erv);
        chk("rd_finish", rd_finish, erf);
        for (int i = 0; i < NUM_RD; i++)
            if (erv[i]) chk("rd_data", rd_data, mem[rd_a[i][10:3] + rd_k[i]]);
        ewg = (mw_own >= 0) ? (NUM_WR'(1) << mw_own) : '0;
        ewv = (mw_own >= 0 && !mw_iss && burst_write_valid) ? ewg : '0;
        ewf = (mw_own >= 0 && !mw_iss && burst_write_finish) ? ewg : '0;
        ewd = (mw_own >= 0) ? wr_data[mw_own*DW +: DW] : '0;
        chk("wr_grant", wr_grant, ewg);
        chk("burst_write_req", burst_write_req, (mw_own >= 0 && mw_iss));
        if (mw_own >= 0 && mw_iss) begin
            chk("burst_write_addr", burst_write_addr, mw_addr);
            chk("burst_write_len", burst_write_len, mw_len);
        end
        chk("wr_valid", wr_valid, ewv);
        chk("wr_finish", wr_finish, ewf);
        chk("burst_write_data", burst_write_data, ewd);

        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_valid[i]) begin
                rd_beats[i]++;
                rd_k[i] = rd_k[i] + 8'd1;
                if (!got_first) first_rd_data = rd_data;
                got_first = 1'b1;
                last_rd_data = rd_data;
            end
            if (rd_finish[i]) begin rd_fin[i]++; rd_k[i] = 8'd0; end
            if (burst_read_req && rd_grant[i]) rd_order.push_back(i);
            if (user_rst) rd_k[i] = 8'd0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_valid[i]) wr_beats[i]++;
            if (wr_finish[i]) wr_fin[i]++;
            if (burst_write_req && wr_grant[i]) wr_order.push_back(i);
        end
        if (burst_read_req) begin last_ra = burst_read_addr; last_rl = burst_read_len; end
        if (burst_write_req) begin last_wa = burst_write_addr; last_wl = burst_write_len; end
        if (rd_grant != '0 && wr_grant != '0) both_seen = 1'b1;

        if (user_rst) begin
            mr_own = -1; mr_iss = 0; mr_ptr = 0;
            mw_own = -1; mw_iss = 0; mw_ptr = 0;
        end else begin
            if (mr_own < 0) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    int c;
                    c = (mr_ptr + k) % NUM_RD;
                    if (mr_own < 0 && rd_req[c]) begin
                        mr_own = c; mr_iss = 1; mr_addr = rd_a[c]; mr_len = rd_l[c];
                    end
                end
            end else if (mr_iss) mr_iss = 0;
            else if (burst_read_finish) begin
                mr_ptr = (mr_own + 1) % NUM_RD;
                mr_own = -1;
            end
            if (mw_own < 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    int c;
                    c = (mw_ptr + k) % NUM_WR;
                    if (mw_own < 0 && wr_req[c]) begin
                        mw_own = c; mw_iss = 1; mw_addr = wr_a[c]; mw_len = wr_l[c];
                    end
                end
            end else if (mw_iss) mw_iss = 0;
            else if (burst_write_finish) begin
                mw_ptr = (mw_own + 1) % NUM_WR;
                mw_own = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
        drive();
        @(negedge user_clk);
        sample();
    endtask

    task automatic run_idle(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (rd_want.sum() == 0 && wr_want.sum() == 0 && rd_grant == '0 && wr_grant == '0
                && !drd_busy && !dwr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_completes"}, ok, 1);
    endtask

    int exp_fair [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hD000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < NUM_RD; i++) begin
            rd_want[i] = 0; rd_a[i] = '0; rd_l[i] = '0; rd_k[i] = 8'd0;
        end
        for (int i = 0; i < NUM_WR; i++) begin
            wr_want[i] = 0; wr_a[i] = '0; wr_l[i] = '0; wr_base[i] = '0; wr_k[i] = 8'd0;
        end
        s_rd_fin = '0; s_wr_vld = '0; s_wr_fin = '0;
        mr_own = -1; mr_iss = 0; mr_ptr = 0; mr_addr = '0; mr_len = '0;
        mw_own = -1; mw_iss = 0; mw_ptr = 0; mw_addr = '0; mw_len = '0;
        drd_busy = 0; dwr_busy = 0; drd_wait = 0; dwr_wait = 0; dwr_cur = 8'd0;
        clr_stats();

        // Reset
        rst_want = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        step();
        chk("reset_rd_grant", rd_grant, 0);
        chk("reset_wr_grant", wr_grant, 0);
        chk("reset_burst_read_req", burst_read_req, 0);
        chk("reset_burst_write_req", burst_write_req, 0);
        chk("reset_burst_read_addr", burst_read_addr, 0);
        chk("reset_burst_read_len", burst_read_len, 0);
        chk("reset_burst_write_addr", burst_write_addr, 0);
        chk("reset_burst_write_len", burst_write_len, 0);
        rst_want = 1'b0;
        step();

        // Single read: master 2, 0x100, len 4 -> words 0x20..0x23
        clr_stats();
        rd_a[2] = 32'h100; rd_l[2] = 8'd4; rd_want[2] = 1;
        run_idle("single_read", 60);
        chk("single_order_n", rd_order.size(), 1);
        if (rd_order.size() > 0) chk("single_order0", rd_order[0], 2);
        chk("single_addr", last_ra, 32'h100);
        chk("single_len", last_rl, 4);
        chk("single_beats2", rd_beats[2], 4);
        chk("single_fin2", rd_fin[2], 1);
        chk("single_other_beats", rd_beats[0] + rd_beats[1] + rd_beats[3], 0);
        chk("single_first_data", first_rd_data, 64'hD000_0000_0000_0020);
        chk("single_last_data", last_rd_data, 64'hD000_0000_0000_0023);

        // Serve master 3 alone, then masters 0 and 3 together: pointer wraps to 0
        clr_stats();
        rd_a[3] = 32'h180; rd_l[3] = 8'd1; rd_want[3] = 1;
        run_idle("solo3", 60);
        rd_a[0] = 32'h000; rd_l[0] = 8'd1; rd_want[0] = 1; rd_want[3] = 1;
        run_idle("wrap", 80);
        chk("wrap_order_n", rd_order.size(), 3);
        if (rd_order.size() == 3) begin
            chk("wrap_order0", rd_order[0], 3);
            chk("wrap_order1", rd_order[1], 0);
            chk("wrap_order2", rd_order[2], 3);
        end

        // Fairness: all four request, len 2 each
        clr_stats();
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a[i] = 32'(i * 64); rd_l[i] = 8'd2;
        end
        rd_want[0] = 2; rd_want[1] = 2; rd_want[2] = 1; rd_want[3] = 1;
        run_idle("fair", 200);
        chk("fair_order_n", rd_order.size(), 6);
        for (int i = 0; i < 6 && i < rd_order.size(); i++) chk("fair_order", rd_order[i], exp_fair[i]);
        chk("fair_beats0", rd_beats[0], 4);
        chk("fair_beats1", rd_beats[1], 4);
        chk("fair_beats2", rd_beats[2], 2);
        chk("fair_beats3", rd_beats[3], 2);

        // Concurrent channels: read master 1 len 8, write master 0 0x200 len 3 data A,B,C
        clr_stats();
        rd_a[1] = 32'h300; rd_l[1] = 8'd8; rd_want[1] = 1;
        wr_a[0] = 32'h200; wr_l[0] = 8'd3; wr_base[0] = 64'hA; wr_want[0] = 1;
        run_idle("concurrent", 100);
        chk("conc_mem40", mem[8'h40], 64'hA);
        chk("conc_mem41", mem[8'h41], 64'hB);
        chk("conc_mem42", mem[8'h42], 64'hC);
        chk("conc_mem43_untouched", mem[8'h43], 64'hD000_0000_0000_0043);
        chk("conc_rd_beats1", rd_beats[1], 8);
        chk("conc_wr_beats0", wr_beats[0], 3);
        chk("conc_wr_fin0", wr_fin[0], 1);
        chk("conc_overlap", both_seen, 1);
        chk("conc_first_data", first_rd_data, 64'hD000_0000_0000_0060);
        chk("conc_last_data", last_rd_data, 64'hD000_0000_0000_0067);

        // Zero-length write from master 1
        clr_stats();
        wr_a[1] = 32'h280; wr_l[1] = 8'd0; wr_base[1] = 64'h55; wr_want[1] = 1;
        run_idle("zero_len", 40);
        chk("zero_order_n", wr_order.size(), 1);
        if (wr_order.size() > 0) chk("zero_order0", wr_order[0], 1);
        chk("zero_addr", last_wa, 32'h280);
        chk("zero_len", last_wl, 0);
        chk("zero_beats1", wr_beats[1], 0);
        chk("zero_fin1", wr_fin[1], 1);
        chk("zero_idle_grant", wr_grant, 0);

        // Reset mid-burst: read master 2 len 16, reset after 5 beats
        clr_stats();
        rd_a[2] = 32'h100; rd_l[2] = 8'd16; rd_want[2] = 1;
        begin
            bit ok;
            ok = 1'b0;
            for (int c = 0; c < 60; c++) begin
                step();
                if (rd_beats[2] >= 5) begin ok = 1'b1; break; end
            end
            chk("midrst_reach_5_beats", ok, 1);
        end
        rst_want = 1'b1;
        for (int i = 0; i < NUM_RD; i++) rd_want[i] = 0;
        step();
        step();
        rst_want = 1'b0;
        step();
        chk("midrst_no_finish", rd_fin[2], 0);
        chk("midrst_beats_lt16", rd_beats[2] < 16, 1);
        chk("midrst_rd_grant", rd_grant, 0);
        chk("midrst_wr_grant", wr_grant, 0);
        chk("midrst_read_addr", burst_read_addr, 0);
        clr_stats();
        rd_a[1] = 32'h040; rd_l[1] = 8'd2; rd_want[1] = 1;
        rd_a[3] = 32'h0C0; rd_l[3] = 8'd2; rd_want[3] = 1;
        run_idle("post_reset", 80);
        chk("postrst_order_n", rd_order.size(), 2);
        if (rd_order.size() == 2) begin
            chk("postrst_order0", rd_order[0], 1);
            chk("postrst_order1", rd_order[1], 3);
        end
        chk("postrst_fin1", rd_fin[1], 1);
        chk("postrst_fin3", rd_fin[3], 1);
        chk("postrst_beats", rd_beats[1] + rd_beats[3], 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
- Round-robin arbiter that shares the single DDR burst user interface between multiple on-chip masters.
- Masters include the Q/K/V weight loaders, the spike/activation fetchers and the result writeback.
- The read and write channels are arbitrated independently; each channel holds at most one outstanding burst at a time.
- Sits between the compute-side loaders/writers and the DDR controller (or the DDR simulation model in benches).

Parameters:
- NUM_RD, 4, number of read requesters (>=1).
- NUM_WR, 2, number of write requesters (>=1).
- Data, address and length widths come from the shared hyper-parameter header macros: `DATA_WIDTH, `ADDR_SIZE, `LEN_WIDTH.

Ports:
- user_clk  in  1  system clock.
- user_rst  in  1  synchronous active-high reset.
- rd_req  in  NUM_RD  level request per read master.
- rd_addr  in  NUM_RD*`ADDR_SIZE  flattened byte addresses; slot i = bits [i*`ADDR_SIZE +: `ADDR_SIZE].
- rd_len  in  NUM_RD*`LEN_WIDTH  flattened beat counts.
- rd_grant  out  NUM_RD  one-hot, high while master i owns the read channel.
- rd_data  out  `DATA_WIDTH  read data, broadcast to all read masters.
- rd_valid  out  NUM_RD  per-master read beat strobe.
- rd_finish  out  NUM_RD  per-master end-of-burst pulse.
- wr_req  in  NUM_WR  level request per write master.
- wr_addr  in  NUM_WR*`ADDR_SIZE  flattened write addresses.
- wr_len  in  NUM_WR*`LEN_WIDTH  flattened write lengths.
- wr_data  in  NUM_WR*`DATA_WIDTH  flattened write data.
- wr_grant  out  NUM_WR  one-hot write ownership.
- wr_valid  out  NUM_WR  per-master "beat consumed, present next word".
- wr_finish  out  NUM_WR  per-master end-of-burst pulse.
- burst_read_addr/len/req  out  `ADDR_SIZE/`LEN_WIDTH/1  to DDR.
- burst_read_data/valid/finish  in  `DATA_WIDTH/1/1  from DDR.
- burst_write_addr/len/req/data  out  `ADDR_SIZE/`LEN_WIDTH/1/`DATA_WIDTH  to DDR.
- burst_write_valid/finish  in  1/1  from DDR.

Behaviour:
- Clock and reset: one clock, user_clk; user_rst is synchronous, active-high.
- Reset values:
  - rd_grant, wr_grant, burst_read_req, burst_write_req = 0.
  - burst_read_addr/len, burst_write_addr/len = 0.
  - Round-robin pointers = 0.
  - FSMs in IDLE.
- Reset asserted mid-burst: the burst is abandoned, no finish is emitted, and the DDR side is reset by the same signal.
- Per-channel FSM (read and write are identical and fully independent):
  - IDLE: if any req is set, select the first requesting index at or after ptr, wrapping modulo N. Register grant one-hot, latch that master's addr/len into burst_*_addr/len, then go to ISSUE.
  - ISSUE: burst_*_req = 1 for exactly this one cycle, then go to BUSY.
  - BUSY: wait for burst_*_finish. In the finish cycle, go to IDLE, clear grant, and set ptr = granted index + 1 (wrap to 0 past N-1).
- Latency: req sampled high in IDLE cycle c -> grant visible in c+1 -> burst_*_req high in c+1 only.
- Routing (combinational, gated by the registered grant):
  - rd_valid[i] = burst_read_valid & rd_grant[i].
  - rd_finish[i] = burst_read_finish & rd_grant[i].
  - rd_data = burst_read_data, unregistered.
  - wr_valid[i] = burst_write_valid & wr_grant[i].
  - wr_finish[i] = burst_write_finish & wr_grant[i].
  - burst_write_data = wr_data slot of the granted master; all zeros when no grant is held.
- Master contract:
  - Hold req, addr and len stable from req assertion until its finish pulse.
  - Deassert req on the finish edge unless another burst is wanted immediately. A held req re-arbitrates fairly: another pending master wins first.
  - Write master: present word k on wr_data before the k-th wr_valid and advance on wr_valid, since the DDR side captures data in the valid cycle.
- Boundary cases:
  - Master drops req before grant: it is not served. Once granted, the burst completes regardless of req.
  - len = 0: burst issued as normal; master gets finish with no valid beats.
  - All masters requesting: strict rotation 0,1,2,...,N-1,0.
  - Single requester: back-to-back bursts separated by ≥2 idle cycles (IDLE+ISSUE), no starvation.
  - burst_*_valid/finish arriving in IDLE or ISSUE: ignored, never routed.
  - Read and write finishing in the same cycle: both handled independently.
  - rd_req == 0: ptr unchanged.

Test Plan:
- Single read: master 2 requests addr 0x100, len 4 with DDR model preloaded. Required: burst_read_req pulse with addr 0x100, len 4; exactly 4 rd_valid[2] strobes carrying mem[0x20..0x23]; one rd_finish[2]; rd_valid[0,1,3] stay 0.
- Fairness: all 4 read masters request continuously, len 2 each. Required: grant order 0,1,2,3,0,1; each master gets 2 beats per turn.
- Concurrent channels: read master 1 (len 8) and write master 0 (addr 0x200, len 3, data 0xA,0xB,0xC) start in the same cycle. Required: both bursts proceed overlapped; mem[0x40..0x42] = 0xA,0xB,0xC; read data is correct.
- Zero length: write master 1 requests len 0. Required: burst_write_req pulse, no wr_valid, one wr_finish[1], FSM back in IDLE.
- Reset mid-burst: read len 16, assert user_rst after 5 beats. Required: grants 0, no rd_finish; a fresh len-2 request after reset completes normally and is granted to the lowest requesting index (ptr = 0).
- Pointer wrap: read masters 3 and 0 request after master 3 was last served. Required: master 0 is granted first, then master 3.
